// File: rtl/ecc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_seq_ctrl
// Brief    : Clock-enable sequencer: ADC groups -> ping-pong buffer -> decoder
// Revision : 1.0
// ============================================================================
module ecc_seq_ctrl #(
    parameter int PERIOD        = 8,
    parameter int DECODE_CYCLES = 11,
    parameter int ADDR_BIT      = 3,
    parameter int CYC_BIT       = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic                BYPASS,
    input  logic                ADC_VALID,
    output logic                ADC_READY,
    output logic                BUF_WE,
    output logic                BUF_BANK_W,
    output logic [ADDR_BIT-1:0] BUF_ADDR,
    output logic                ECC_LOAD,
    output logic                BUF_BANK_R,
    output logic                ECC_EN,
    input  logic                ECC_READY,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_BIT-1:0] C_LAST_ADDR = ADDR_BIT'(PERIOD - 1);
    localparam logic [CYC_BIT-1:0]  C_LAST_CYC  = CYC_BIT'(DECODE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic [ADDR_BIT-1:0] waddr_q, waddr_d;
    logic [CYC_BIT-1:0]  cyc_q, cyc_d;
    logic                overrun_q, overrun_d;
    logic                w_ready;
    logic                w_accept;

    always_comb begin
        // Ready is held low while reset is asserted so no group is offered then
        w_ready   = CE & RST_N & ~full_q[wptr_q];
        w_accept  = ADC_VALID & w_ready;

        state_d   = state_q;
        full_d    = full_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        waddr_d   = waddr_q;
        cyc_d     = cyc_q;
        overrun_d = overrun_q;

        if (w_accept) begin
            if (waddr_q == C_LAST_ADDR) begin
                full_d[wptr_q] = 1'b1;
                wptr_d         = ~wptr_q;
                waddr_d        = '0;
            end else begin
                waddr_d = waddr_q + 1'b1;
            end
        end

        if (CE & ADC_VALID & ~w_ready) begin
            overrun_d = 1'b1;
        end

        // The bank is released at LOAD; it never collides with a fill-side set
        if (CE) begin
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rptr_q]) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    full_d[rptr_q] = 1'b0;
                    rptr_d         = ~rptr_q;
                    cyc_d          = '0;
                    state_d        = ST_RUN;
                end
                ST_RUN: begin
                    cyc_d = cyc_q + 1'b1;
                    if ((cyc_q == C_LAST_CYC) || ECC_READY || BYPASS) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (OUT_READY) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            full_q    <= 2'b00;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            waddr_q   <= '0;
            cyc_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            waddr_q   <= waddr_d;
            cyc_q     <= cyc_d;
            overrun_q <= overrun_d;
        end
    end

    assign ADC_READY  = w_ready;
    assign BUF_WE     = w_accept;
    assign BUF_BANK_W = wptr_q;
    assign BUF_ADDR   = waddr_q;
    assign ECC_LOAD   = CE & (state_q == ST_LOAD);
    assign BUF_BANK_R = rptr_q;
    assign ECC_EN     = CE & (state_q == ST_RUN);
    assign OUT_VALID  = (state_q == ST_HOLD);
    assign OVERRUN    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_seq_ctrl
// Brief    : Self-checking bench for ecc_seq_ctrl against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_ecc_seq_ctrl;

    localparam int PERIOD = 8;
    localparam int DEC    = 11;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CE = 1'b0;
    logic       BYPASS = 1'b0;
    logic       ADC_VALID = 1'b0;
    logic       ECC_READY = 1'b0;
    logic       OUT_READY = 1'b0;
    logic       ADC_READY, BUF_WE, BUF_BANK_W, ECC_LOAD, BUF_BANK_R, ECC_EN, OUT_VALID, OVERRUN;
    logic [2:0] BUF_ADDR;

    ecc_seq_ctrl #(.PERIOD(PERIOD), .DECODE_CYCLES(DEC), .ADDR_BIT(3), .CYC_BIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .BYPASS(BYPASS), .ADC_VALID(ADC_VALID),
        .ADC_READY(ADC_READY), .BUF_WE(BUF_WE), .BUF_BANK_W(BUF_BANK_W), .BUF_ADDR(BUF_ADDR),
        .ECC_LOAD(ECC_LOAD), .BUF_BANK_R(BUF_BANK_R), .ECC_EN(ECC_EN), .ECC_READY(ECC_READY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: banks waiting for the decoder in fill order, plus a decode phase
    // (0 idle, 1 load, 2 run, 3 hold) and the number of enable cycles spent.
    int  wbank, wslot, phase, runs, loads;
    bit  ovr;
    int  pend[$];

    // Vector order: {ADC_READY, BUF_WE, BUF_BANK_W, BUF_ADDR[2:0], ECC_LOAD, BUF_BANK_R, ECC_EN, OUT_VALID, OVERRUN}
    logic [10:0] got, exp_v;

    function automatic bit in_pend(int b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] model_out(bit ce, bit av);
        bit ar;
        ar = ce && !in_pend(wbank);
        return {ar, av && ar, wbank[0], 3'(wslot), ce && (phase == 1), loads[0],
                ce && (phase == 2), phase == 3, ovr};
    endfunction

    task automatic model_reset();
        wbank = 0; wslot = 0; phase = 0; runs = 0; loads = 0; ovr = 1'b0;
        pend.delete();
    endtask

    task automatic model_step(bit ce, bit av, bit er, bit byp, bit ordy);
        bit ar, had;
        ar  = ce && !in_pend(wbank);
        had = pend.size() > 0;
        if (ce && av && !ar) ovr = 1'b1;
        if (ce) begin
            case (phase)
                0: if (had) phase = 1;
                1: begin pend.delete(0); loads++; runs = 0; phase = 2; end
                2: begin runs++; if (runs == DEC || er || byp) phase = 3; end
                default: if (ordy) phase = 0;
            endcase
        end
        if (av && ar) begin
            wslot++;
            if (wslot == PERIOD) begin
                pend.push_back(wbank);
                wbank = wbank ^ 1;
                wslot = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, capture DUT and model outputs, advance both.
    task automatic drive(bit ce, bit av, bit er, bit byp, bit ordy);
        CE = ce; ADC_VALID = av; ECC_READY = er; BYPASS = byp; OUT_READY = ordy;
        #2;
        exp_v = model_out(ce, av);
        got   = {ADC_READY, BUF_WE, BUF_BANK_W, BUF_ADDR, ECC_LOAD, BUF_BANK_R, ECC_EN, OUT_VALID, OVERRUN};
        @(posedge CLK);
        model_step(ce, av, er, byp, ordy);
        #1;
    endtask

    task automatic do_reset();
        CE = 1'b0; ADC_VALID = 1'b0; ECC_READY = 1'b0; BYPASS = 1'b0; OUT_READY = 1'b0;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        CE = 1'b1;
        #12;
        got = {ADC_READY, BUF_WE, BUF_BANK_W, BUF_ADDR, ECC_LOAD, BUF_BANK_R, ECC_EN, OUT_VALID, OVERRUN};
        checks++;
        if (got !== 11'd0) begin errors++; $display("FAIL reset_outputs got %b exp %b", got, 11'd0); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        checks++;
        if (ADC_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ADC_READY); end
    endtask

    task automatic test_single();
        int ld = -1, ovi = -1, en = 0;
        logic ldbank = 1'b1;
        for (int i = 0; i < 26; i++) begin
            drive(1, i < 8, 0, 0, 0);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL single cyc%0d got %b exp %b", i, got, exp_v); end
            if (i < 8) begin
                checks++;
                if (got[7:5] !== 3'(i) || got[8] !== 1'b0) begin
                    errors++; $display("FAIL single_addr cyc%0d got %0d/%b exp %0d/0", i, got[7:5], got[8], i);
                end
            end
            if (got[4] && ld < 0) begin ld = i; ldbank = got[3]; end
            if (got[2]) en++;
            if (got[1] && ovi < 0) ovi = i;
        end
        checks++;
        if (ld !== 9 || ldbank !== 1'b0) begin errors++; $display("FAIL single_load got cyc%0d bank%b exp cyc9 bank0", ld, ldbank); end
        checks++;
        if (en !== DEC) begin errors++; $display("FAIL single_en_count got %0d exp %0d", en, DEC); end
        checks++;
        if (ovi !== 21) begin errors++; $display("FAIL single_out_valid got cyc%0d exp cyc21", ovi); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL single_drain cyc%0d got %b exp %b", i, got, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic lb[$];
        bit overlap = 1'b0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive(1, i < 16, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL b2b cyc%0d got %b exp %b", i, got, exp_v); end
            if (got[4]) lb.push_back(got[3]);
            if (got[9] && got[8] && got[2]) overlap = 1'b1;
        end
        checks++;
        if (lb.size() != 2 || lb[0] !== 1'b0 || lb[1] !== 1'b1) begin
            errors++; $display("FAIL b2b_load_banks got n=%0d exp n=2 banks 0,1", lb.size());
        end
        checks++;
        if (!overlap) begin errors++; $display("FAIL b2b_overlap got 0 exp 1"); end
        checks++;
        if (OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", OVERRUN); end
    endtask

    task automatic test_early();
        for (int byp = 0; byp < 2; byp++) begin
            int fed = 0, en = 0;
            for (int i = 0; i < 30; i++) begin
                drive(1, fed < 8, (byp == 0) && (phase == 2) && (runs == 3), byp[0], 1);
                checks++;
                if (got !== exp_v) begin errors++; $display("FAIL early b%0d cyc%0d got %b exp %b", byp, i, got, exp_v); end
                if (got[9]) fed++;
                if (got[2]) en++;
            end
            checks++;
            if (en !== (byp ? 1 : 4)) begin errors++; $display("FAIL early_en b%0d got %0d exp %0d", byp, en, byp ? 1 : 4); end
        end
    endtask

    task automatic test_ce_freeze();
        int fed = 0, en = 0, after = 0, frz = 0;
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done && phase == 2 && runs == 6) begin frz = 5; done = 1'b1; end
            drive(frz == 0, fed < 8, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ce_freeze cyc%0d got %b exp %b", i, got, exp_v); end
            if (got[9]) fed++;
            if (got[2]) begin en++; if (done) after++; end
            if (frz > 0) begin
                checks++;
                if (got[2] !== 1'b0) begin errors++; $display("FAIL ce_freeze_en cyc%0d got 1 exp 0", i); end
                frz--;
            end
        end
        checks++;
        if (en !== DEC || after !== 5) begin errors++; $display("FAIL ce_freeze_count got %0d/%0d exp %0d/5", en, after, DEC); end
    endtask

    task automatic test_overrun();
        int acc = 0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(1, i < 8, 0, 0, 0);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ovr_fill cyc%0d got %b exp %b", i, got, exp_v); end
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ovr cyc%0d got %b exp %b", i, got, exp_v); end
            if (got[9]) acc++;
        end
        checks++;
        if (acc !== 16) begin errors++; $display("FAIL ovr_accepts got %0d exp 16", acc); end
        checks++;
        if (got[10] !== 1'b0 || got[0] !== 1'b1 || got[7:5] !== 3'd0) begin
            errors++; $display("FAIL ovr_state got rdy%b ovr%b addr%0d exp rdy0 ovr1 addr0", got[10], got[0], got[7:5]);
        end
        for (int i = 0; i < 60; i++) begin
            drive(1, 0, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ovr_drain cyc%0d got %b exp %b", i, got, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 40 && !(phase == 2 && runs == 3); i++) begin
            drive(1, i < 8, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL arst_pre cyc%0d got %b exp %b", i, got, exp_v); end
        end
        CE = 1'b1; ADC_VALID = 1'b0; OUT_READY = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        got = {ADC_READY, BUF_WE, BUF_BANK_W, BUF_ADDR, ECC_LOAD, BUF_BANK_R, ECC_EN, OUT_VALID, OVERRUN};
        checks++;
        if (got !== 11'd0) begin errors++; $display("FAIL arst_outputs got %b exp %b", got, 11'd0); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, i < 8, 0, 0, 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL arst_post cyc%0d got %b exp %b", i, got, exp_v); end
            if (i < 8) begin
                checks++;
                if (got[7:5] !== 3'(i) || got[8] !== 1'b0) begin
                    errors++; $display("FAIL arst_addr cyc%0d got %0d/%b exp %0d/0", i, got[7:5], got[8], i);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL random cyc%0d got %b exp %b", i, got, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_early();
        test_ce_freeze();
        test_overrun();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
